dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller in the MEM stage of the 5-stage RISC-V pipeline.
- It produces the mem_stall signal consumed by the hazard unit.
- Read hits return data in the same cycle. Read misses refill a full line from main memory over a req/ack handshake. Writes go through to memory and stall until acknowledged.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 for RV32.
- SETS, 64, number of lines; power of 2.
- LINE_WORDS, 4, words per line; power of 2, at least 2.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- memoryRead_m, input, 1, load in MEM stage.
- memoryWrite_m, input, 1, store in MEM stage.
- addr_m, input, ADDR_WIDTH, byte address; bits [1:0] are ignored (word access only).
- wdata_m, input, DATA_WIDTH, store data.
- rdata_m, output, DATA_WIDTH, load data; valid when memoryRead_m=1 and mem_stall=0.
- mem_stall, output, 1, pipeline stall request to the hazard unit.
- mem_req, output, 1, memory request.
- mem_we, output, 1, 1 = write, 0 = read.
- mem_addr, output, ADDR_WIDTH, word-aligned memory address.
- mem_wdata, output, DATA_WIDTH, write data.
- mem_ack, input, 1, single-cycle completion pulse; may arrive in the same cycle mem_req rises.
- mem_rdata, input, DATA_WIDTH, read data; valid with mem_ack.

Behaviour:
- Address split:
  - offset = addr_m[2+log2(LINE_WORDS)-1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage: data array, tag array, valid bit per line.
  - Reset clears all valid bits, state=IDLE, word counter=0.
  - Data and tag arrays are not reset.
- Reset values: mem_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_m=0 (rdata_m is 0 whenever memoryRead_m=0).
- hit = valid[index] && tag_array[index]==tag.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit: rdata_m = line word [offset], combinational. mem_stall=0. Stay in IDLE.
  - Read miss: mem_stall=1 combinationally in this cycle. Latch line base address (offset bits zeroed). Counter=0. Go to REFILL.
  - Write (hit or miss): mem_stall=1. Go to WRITE.
  - memoryRead_m && memoryWrite_m together is illegal; it is treated as a write.
- REFILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr = base + 4*counter. mem_stall=1 throughout.
  - On mem_ack: store mem_rdata into word [counter]; counter++.
  - On the ack with counter==LINE_WORDS-1: write tag, set valid, counter=0, go to IDLE.
  - The stalled load replays in IDLE the next cycle, hits, and the stall drops.
  - Read-miss penalty = refill ack cycles + 1.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_addr = {addr_m[ADDR_WIDTH-1:2],2'b00}, mem_wdata=wdata_m. mem_stall = !mem_ack.
  - On mem_ack: if hit, update cached word [offset] (no allocate on miss). Go to IDLE.
  - The pipeline advances in the ack cycle.
  - Minimum store latency: 1 stall cycle when mem_ack is returned in the first WRITE cycle.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ack not yet received. mem_req is deasserted in IDLE.
- Cache inputs (addr_m, wdata_m, memoryRead_m, memoryWrite_m) are held stable by the pipeline while mem_stall=1.
- Reset mid-refill: immediate return to IDLE, line stays invalid, mem_req drops asynchronously.
- mem_ack outside REFILL/WRITE is ignored.
- Index aliasing: a refill overwrites the resident line unconditionally; no dirty state exists.

Test Plan:
- Cold read 0x100, memory acks 1 cycle after each req → 4 reads at 0x100/0x104/0x108/0x10C, mem_stall high for 9 cycles, then rdata_m = mem[0x100]; a read of 0x104 next is a hit with 0 stall.
- Read hit after fill → same-cycle rdata_m, mem_req stays 0.
- Write 0xDEADBEEF to cached 0x108, ack in the first cycle → 1 stall cycle, mem_we=1; a subsequent read of 0x108 returns 0xDEADBEEF with no refill.
- Write to uncached 0x2000 → memory write issued; a following read of 0x2000 misses and refills (no allocate).
- Conflict: read 0x100 then 0x100 + SETS*16 = 0x500 → second refills; a re-read of 0x100 misses again.
- Assert rst_n=0 after 2 refill acks → outputs go to reset values immediately; a re-read of 0x100 performs a full 4-word refill.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the
// MEM stage. Read hits complete combinationally; read misses refill a whole
// line over a req/ack handshake; stores always go through to memory.
module dcache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memoryRead_m,
    input  logic                  memoryWrite_m,
    input  logic [ADDR_WIDTH-1:0] addr_m,
    input  logic [DATA_WIDTH-1:0] wdata_m,
    output logic [DATA_WIDTH-1:0] rdata_m,
    output logic                  mem_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int LINE_W = ADDR_WIDTH - 2 - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [OFF_W-1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0]       line_addr_q, line_addr_d;
    logic [SETS-1:0]         valid_q, valid_d;

    logic [DATA_WIDTH-1:0]   data_arr [SETS*LINE_WORDS];
    logic [TAG_W-1:0]        tag_arr  [SETS];

    logic                    data_we;
    logic [IDX_W+OFF_W-1:0]  data_waddr;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    tag_we;
    logic [IDX_W-1:0]        tag_widx;
    logic [TAG_W-1:0]        tag_wdata;

    // Byte-offset bits are dropped: the cache only serves whole words.
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [OFF_W-1:0]        req_off;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [LINE_W-1:0]       req_line;
    logic [IDX_W-1:0]        fill_idx;
    logic                    hit;

    assign word_addr = addr_m & ~ADDR_WIDTH'(3);
    assign req_off   = word_addr[2 +: OFF_W];
    assign req_idx   = word_addr[2+OFF_W +: IDX_W];
    assign req_tag   = word_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_line  = word_addr[ADDR_WIDTH-1 -: LINE_W];
    assign fill_idx  = line_addr_q[IDX_W-1:0];
    assign hit       = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

    // Control state: FSM, refill word counter, latched line address, valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Data and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (data_we) data_arr[data_waddr] <= data_wdata;
        if (tag_we)  tag_arr[tag_widx]    <= tag_wdata;
    end

    // Next-state, handshake outputs and array write ports; all outputs held at
    // their idle values while reset is asserted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        valid_d     = valid_q;
        rdata_m     = '0;
        mem_stall   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        data_we     = 1'b0;
        data_waddr  = '0;
        data_wdata  = '0;
        tag_we      = 1'b0;
        tag_widx    = '0;
        tag_wdata   = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    // A simultaneous read+write request is handled as a store.
                    if (memoryWrite_m) begin
                        mem_stall = 1'b1;
                        state_d   = WRITE;
                    end else if (memoryRead_m) begin
                        if (hit) begin
                            rdata_m = data_arr[{req_idx, req_off}];
                        end else begin
                            mem_stall   = 1'b1;
                            line_addr_d = req_line;
                            cnt_d       = '0;
                            state_d     = REFILL;
                        end
                    end
                end
                REFILL: begin
                    mem_req   = 1'b1;
                    mem_addr  = {line_addr_q, cnt_q, 2'b00};
                    mem_stall = 1'b1;
                    if (mem_ack) begin
                        data_we    = 1'b1;
                        data_waddr = {fill_idx, cnt_q};
                        data_wdata = mem_rdata;
                        cnt_d      = cnt_q + OFF_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            // Line complete: the stalled load replays and hits next cycle.
                            cnt_d             = '0;
                            tag_we            = 1'b1;
                            tag_widx          = fill_idx;
                            tag_wdata         = line_addr_q[LINE_W-1 -: TAG_W];
                            valid_d[fill_idx] = 1'b1;
                            state_d           = IDLE;
                        end
                    end
                end
                WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = wdata_m;
                    mem_stall = !mem_ack;
                    if (mem_ack) begin
                        // Keep a resident copy coherent; misses are not allocated.
                        if (hit) begin
                            data_we    = 1'b1;
                            data_waddr = {req_idx, req_off};
                            data_wdata = wdata_m;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a behavioural memory with configurable
// ack latency, plus a reference model of line residency and memory contents.
module tb_dcache_ctrl;

    localparam int SETS = 64;
    localparam int LW   = 4;

    logic        clk, rst_n;
    logic        memoryRead_m, memoryWrite_m;
    logic [31:0] addr_m, wdata_m, rdata_m;
    logic        mem_stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    dcache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .memoryRead_m(memoryRead_m), .memoryWrite_m(memoryWrite_m),
        .addr_m(addr_m), .wdata_m(wdata_m), .rdata_m(rdata_m),
        .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural main memory ----------------
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] gold [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    int lat = 1;
    int wait_cnt = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : init_val(a);
    endfunction

    // Each request is acknowledged after 'lat' wait cycles; ack is one cycle wide.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt >= lat) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_log.push_back(mem_addr);
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
                    rd_log.push_back(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- reference model of cache residency ----------------
    bit          m_valid[SETS];
    logic [21:0] m_tag[SETS];

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int l, input string nm);
        logic [31:0] word, base, got, exp_data;
        logic [21:0] tag;
        int idx, exp_stall, stalls;
        bit exp_hit, done, saw_req, ok;
        word      = a & ~32'h3;
        base      = word & ~32'hF;
        idx       = int'(word[9:4]);
        tag       = word[31:10];
        exp_hit   = m_valid[idx] && (m_tag[idx] == tag);
        exp_stall = exp_hit ? 0 : LW * (l + 1) + 1;
        exp_data  = gold_rd(word);
        lat = l;
        rd_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        addr_m = a; memoryWrite_m = 1'b0; memoryRead_m = 1'b1;
        stalls = 0; done = 1'b0; saw_req = 1'b0; got = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); #1;
            if (mem_req) saw_req = 1'b1;
            if (mem_stall) stalls++;
            else begin done = 1'b1; got = rdata_m; end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL %s_timeout addr=%h stall never dropped", nm, a); end
        checks++;
        if (stalls !== exp_stall) begin
            failures++; $display("FAIL %s_stall addr=%h got=%0d exp=%0d", nm, a, stalls, exp_stall);
        end
        checks++;
        if (got !== exp_data) begin
            failures++; $display("FAIL %s_rdata addr=%h got=%h exp=%h", nm, a, got, exp_data);
        end
        if (exp_hit) ok = !saw_req && rd_log.size() == 0;
        else begin
            ok = (rd_log.size() == LW) && (wr_log.size() == 0);
            for (int k = 0; k < LW && ok; k++) if (rd_log[k] !== base + 32'(4 * k)) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_traffic addr=%h reads=%0d exp_reads=%0d", nm, a, rd_log.size(), exp_hit ? 0 : LW);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        @(posedge clk); #1;
        memoryRead_m = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int l,
                            input bit also_read, input string nm);
        logic [31:0] word;
        int exp_stall, stalls;
        bit done, saw_we, ok;
        word      = a & ~32'h3;
        exp_stall = 1 + l;
        lat = l;
        rd_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        addr_m = a; wdata_m = d; memoryWrite_m = 1'b1; memoryRead_m = also_read;
        stalls = 0; done = 1'b0; saw_we = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); #1;
            if (mem_req && mem_we) saw_we = 1'b1;
            if (mem_stall) stalls++;
            else done = 1'b1;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL %s_timeout addr=%h stall never dropped", nm, a); end
        checks++;
        if (stalls !== exp_stall) begin
            failures++; $display("FAIL %s_stall addr=%h got=%0d exp=%0d", nm, a, stalls, exp_stall);
        end
        checks++;
        if (!saw_we) begin failures++; $display("FAIL %s_we addr=%h got=0 exp=1", nm, a); end
        ok = (wr_log.size() == 1) && (rd_log.size() == 0) && (wr_log[0] === word);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL %s_traffic addr=%h writes=%0d reads=%0d exp=1/0", nm, a, wr_log.size(), rd_log.size());
        end
        checks++;
        if (!mem.exists(word) || mem[word] !== d) begin
            failures++; $display("FAIL %s_memdata addr=%h exp=%h", nm, word, d);
        end
        gold[word] = d;
        @(posedge clk); #1;
        memoryWrite_m = 1'b0; memoryRead_m = 1'b0;
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if (mem_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL %s_ctrl stall=%b req=%b we=%b exp=000", nm, mem_stall, mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL %s_bus addr=%h wdata=%h exp=0/0", nm, mem_addr, mem_wdata);
        end
        checks++;
        if (rdata_m !== 32'h0) begin
            failures++; $display("FAIL %s_rdata got=%h exp=0", nm, rdata_m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; memoryRead_m = 1'b0; memoryWrite_m = 1'b0;
        addr_m = '0; wdata_m = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_cold_read();
        do_read(32'h100, 1, "cold_read");
        do_read(32'h104, 1, "hit_after_fill");
    endtask

    task automatic test_read_hit();
        do_read(32'h10C, 0, "read_hit_a");
        do_read(32'h102, 2, "read_hit_b");
    endtask

    task automatic test_write_hit();
        do_write(32'h108, 32'hDEADBEEF, 0, 1'b0, "write_hit");
        do_read(32'h108, 1, "read_after_write");
    endtask

    task automatic test_write_miss();
        do_write(32'h2000, 32'h12345678, 1, 1'b0, "write_miss");
        do_read(32'h2000, 1, "read_no_alloc");
    endtask

    task automatic test_conflict();
        do_read(32'h100 + SETS * 16, 1, "conflict_evict");
        do_read(32'h100, 0, "conflict_reread");
    endtask

    task automatic test_reset_mid_refill();
        int acks;
        bit ok;
        lat = 1;
        @(posedge clk); #1;
        addr_m = 32'h500; memoryRead_m = 1'b1; memoryWrite_m = 1'b0;
        acks = 0;
        for (int c = 0; c < 50 && acks < 2; c++) begin
            @(negedge clk); #1;
            if (mem_ack) acks++;
        end
        checks++;
        ok = (acks == 2);
        if (!ok) begin failures++; $display("FAIL midreset_acks got=%0d exp=2", acks); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        memoryRead_m = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        do_read(32'h100, 1, "refill_after_reset");
        do_read(32'h500, 0, "refill_after_reset_b");
    endtask

    task automatic test_random();
        logic [31:0] pool[5];
        logic [31:0] a;
        pool[0] = 32'h100; pool[1] = 32'h500; pool[2] = 32'h900;
        pool[3] = 32'h2000; pool[4] = 32'h140;
        for (int i = 0; i < 40; i++) begin
            a = pool[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) do_read(a, int'($urandom_range(0, 2)), "rand_read");
            else do_write(a, $urandom, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, "rand_write");
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
